sha256_host_mem: RTL and testbench

Memory-side responder and host controller for the sha256 core's memory interface. Owns the word RAM the core reads its message from and writes its digest to. Accepts a message from a host stream and loads it, pulses the core's start, and waits for done. It then reads back the 8-word digest and streams it to the host.

---
 rtl/sha256_host_mem.sv | 148 ++++++++++++++
 tb/tb_sha256_host_mem.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_host_mem.sv
// Host-side controller and word RAM for the sha256 core: loads a message from the host,
// starts the core, serves its memory port, then streams the 8-word digest back out.
module sha256_host_mem #(
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [15:0] MSG_BASE   = 16'h0000,
    parameter logic [15:0] OUT_BASE   = 16'h00F0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_size,
    input  logic        msg_valid,
    output logic        msg_ready,
    input  logic [31:0] msg_data,
    output logic        dig_valid,
    input  logic        dig_ready,
    output logic [31:0] dig_data,
    output logic        dig_last,
    output logic        err,
    output logic        busy,
    output logic        core_start,
    output logic [31:0] core_message_addr,
    output logic [31:0] core_size,
    output logic [31:0] core_output_addr,
    input  logic        core_done,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic [2:0]  dbg_state
);
    // Handshake rule for cmd/msg/dig: a transfer happens on a rising clk edge where
    // valid && ready; valid never waits on ready, and payload holds while valid && !ready.

    localparam int          DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [31:0] MAX_WORDS = 32'(OUT_BASE) - 32'(MSG_BASE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [31:0] ram [DEPTH];
    logic [31:0] nwords_q;
    logic [31:0] wptr;
    logic [2:0]  rptr;
    logic        done_q;

    logic [31:0]           cmd_nwords;
    logic                  over_limit, cmd_fire, msg_fire, dig_fire;
    logic                  done_rise, last_word, addr_ok;
    logic [DEPTH_LOG2-1:0] load_addr, drain_addr, core_addr;

    assign core_message_addr = 32'(MSG_BASE);
    assign core_output_addr  = 32'(OUT_BASE);

    assign cmd_nwords = (cmd_size + 32'd3) >> 2;
    assign over_limit = cmd_nwords > MAX_WORDS;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign msg_fire   = msg_valid && msg_ready;
    assign dig_fire   = dig_valid && dig_ready;
    assign done_rise  = core_done && !done_q;
    assign last_word  = (wptr + 32'd1) == nwords_q;
    assign addr_ok    = 32'(mem_addr) < 32'(DEPTH);
    assign core_addr  = mem_addr[DEPTH_LOG2-1:0];
    assign load_addr  = DEPTH_LOG2'(32'(MSG_BASE) + wptr);
    assign drain_addr = DEPTH_LOG2'(32'(OUT_BASE) + 32'(rptr));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cmd_valid && !over_limit)
                         state_nxt = (cmd_nwords == 32'd0) ? S_START : S_LOAD;
            S_LOAD:  if (msg_fire && last_word) state_nxt = S_START;
            S_START: state_nxt = S_RUN;
            // Only a fresh low-to-high done ends the run; a level left over is ignored.
            S_RUN:   if (done_rise) state_nxt = S_DRAIN;
            S_DRAIN: if (dig_fire && dig_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == S_IDLE);
        msg_ready = (state == S_LOAD);
        busy      = (state != S_IDLE);
        dbg_state = state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_size     <= '0;
            nwords_q      <= '0;
            wptr          <= '0;
            rptr          <= '0;
            done_q        <= 1'b0;
            err           <= 1'b0;
            core_start    <= 1'b0;
            dig_valid     <= 1'b0;
            dig_last      <= 1'b0;
            dig_data      <= '0;
            mem_read_data <= '0;
        end else begin
            done_q        <= core_done;
            err           <= cmd_fire && over_limit;
            core_start    <= (state == S_START);
            mem_read_data <= addr_ok ? ram[core_addr] : '0;
            if (cmd_fire && !over_limit) begin
                core_size <= cmd_size;
                nwords_q  <= cmd_nwords;
                wptr      <= '0;
            end
            if (msg_fire) wptr <= wptr + 32'd1;
            if (state == S_RUN && done_rise) rptr <= '0;
            // Each digest word: one cycle to read RAM, then hold it until accepted.
            if (state == S_DRAIN) begin
                if (!dig_valid) begin
                    dig_data  <= ram[drain_addr];
                    dig_last  <= (rptr == 3'd7);
                    dig_valid <= 1'b1;
                end else if (dig_ready) begin
                    dig_valid <= 1'b0;
                    dig_last  <= 1'b0;
                    rptr      <= rptr + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (msg_fire)
            ram[load_addr] <= msg_data;
        else if (state == S_RUN && mem_we && addr_ok)
            ram[core_addr] <= mem_write_data;
    end

endmodule

// File: tb/tb_sha256_host_mem.sv
// Bench for sha256_host_mem: host driver tasks, a behavioural core on the memory port,
// and a digest scoreboard fed when the core writes and drained from the host stream.
module tb_sha256_host_mem;
    localparam logic [15:0] OUT_BASE = 16'h00F0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [31:0] cmd_size = '0;
    logic        msg_valid = 1'b0, msg_ready;
    logic [31:0] msg_data = '0;
    logic        dig_valid, dig_ready = 1'b0, dig_last;
    logic [31:0] dig_data;
    logic        err, busy, core_start;
    logic [31:0] core_message_addr, core_size, core_output_addr;
    logic        core_done = 1'b0, mem_we = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [31:0] mem_write_data = '0, mem_read_data;
    logic [2:0]  dbg_state;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] msg_model [240];
    logic [31:0] abc_dig [8];
    logic [31:0] rnd_dig [8];

    sha256_host_mem dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_size(cmd_size),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
        .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data), .dig_last(dig_last),
        .err(err), .busy(busy), .core_start(core_start),
        .core_message_addr(core_message_addr), .core_size(core_size),
        .core_output_addr(core_output_addr), .core_done(core_done),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // All driver tasks start and end at a falling edge.
    task automatic send_cmd(input logic [31:0] size);
        int t = 0;
        cmd_valid = 1'b1;
        cmd_size  = size;
        while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
        check_eq("cmd_accept", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] data);
        int t = 0;
        msg_valid = 1'b1;
        msg_data  = data;
        while (!msg_ready && t < 100) begin @(negedge clk); t++; end
        if (!msg_ready) check_eq("msg_accept", 32'(msg_ready), 32'd1);
        @(negedge clk);
        msg_valid = 1'b0;
    endtask

    task automatic wait_start();
        int t = 0;
        while (!core_start && t < 100) begin @(negedge clk); t++; end
        check_eq("start_seen", 32'(core_start), 32'd1);
        @(negedge clk);
        check_eq("start_one_cycle", 32'(core_start), 32'd0);
    endtask

    task automatic core_read(input logic [15:0] addr, input logic [31:0] exp, input string tag);
        mem_addr = addr;
        @(negedge clk);
        check_eq(tag, mem_read_data, exp);
    endtask

    task automatic core_write_digest(input logic [31:0] d [8], input bit raise);
        for (int i = 0; i < 8; i++) begin
            mem_we         = 1'b1;
            mem_addr       = OUT_BASE + 16'(i);
            mem_write_data = d[i];
            exp_q.push_back(d[i]);
            @(negedge clk);
        end
        mem_we = 1'b0;
        if (raise) core_done = 1'b1;
    endtask

    task automatic drain(input bit use_bp);
        bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int          got = 0, t = 0, pi = 0;
        bit          stalled = 1'b0;
        logic [31:0] held_data = '0, e;
        logic        held_last = 1'b0;
        while (got < 8 && t < 300) begin
            if (stalled) begin
                check_eq("stall_valid", 32'(dig_valid), 32'd1);
                check_eq("stall_data", dig_data, held_data);
                check_eq("stall_last", 32'(dig_last), 32'(held_last));
            end
            dig_ready = use_bp ? pat[pi % 6] : 1'b1;
            if (dig_valid) pi++;
            if (dig_valid && dig_ready) begin
                check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("dig_data", dig_data, e);
                end
                check_eq("dig_last", 32'(dig_last), 32'(got == 7));
                got++;
                stalled = 1'b0;
            end else if (dig_valid) begin
                stalled   = 1'b1;
                held_data = dig_data;
                held_last = dig_last;
            end else begin
                stalled = 1'b0;
            end
            @(negedge clk);
            t++;
        end
        dig_ready = 1'b0;
        check_eq("drain_count", 32'(got), 32'd8);
        check_eq("drain_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        abc_dig = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

        // Reset state, sampled while reset is held.
        repeat (3) @(negedge clk);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_msg_ready", 32'(msg_ready), 32'd0);
        check_eq("rst_dig_valid", 32'(dig_valid), 32'd0);
        check_eq("rst_dig_last", 32'(dig_last), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_core_start", 32'(core_start), 32'd0);
        check_eq("rst_core_size", core_size, 32'd0);
        check_eq("rst_mem_read_data", mem_read_data, 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'd0);
        check_eq("msg_addr", core_message_addr, 32'h0000_0000);
        check_eq("out_addr", core_output_addr, 32'h0000_00F0);
        reset_n = 1'b1;
        @(negedge clk);

        // "abc"
        send_cmd(32'd3);
        check_eq("abc_busy", 32'(busy), 32'd1);
        check_eq("abc_msg_ready", 32'(msg_ready), 32'd1);
        check_eq("abc_cmd_ready", 32'(cmd_ready), 32'd0);
        send_word(32'h61626300);
        wait_start();
        check_eq("abc_core_size", core_size, 32'd3);
        core_read(16'h0000, 32'h61626300, "abc_ram0");
        core_read(16'h0100, 32'h0, "oob_read");
        mem_we = 1'b1; mem_addr = 16'h0100; mem_write_data = 32'hDEADBEEF;
        @(negedge clk);
        mem_we = 1'b0;
        core_read(16'h0000, 32'h61626300, "oob_write_dropped");
        core_write_digest(abc_dig, 1'b1);
        drain(1'b0);
        core_done = 1'b0;
        @(negedge clk);

        // Empty message: start two edges after the command handshake.
        send_cmd(32'd0);
        check_eq("zero_start_lat1", 32'(core_start), 32'd0);
        check_eq("zero_no_msg_ready1", 32'(msg_ready), 32'd0);
        @(negedge clk);
        check_eq("zero_start_lat2", 32'(core_start), 32'd1);
        check_eq("zero_no_msg_ready2", 32'(msg_ready), 32'd0);
        @(negedge clk);
        check_eq("zero_start_end", 32'(core_start), 32'd0);
        for (int i = 0; i < 8; i++) rnd_dig[i] = $urandom;
        core_write_digest(rnd_dig, 1'b1);
        drain(1'b1);
        core_done = 1'b0;
        @(negedge clk);

        // Over-limit command is rejected.
        send_cmd(32'd961);
        check_eq("err_pulse", 32'(err), 32'd1);
        check_eq("err_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("err_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_eq("err_one_cycle", 32'(err), 32'd0);
        check_eq("err_no_start", 32'(core_start), 32'd0);

        // Largest legal message, with a stray core write during the load.
        send_cmd(32'd960);
        for (int i = 0; i < 240; i++) begin
            msg_model[i] = $urandom;
            send_word(msg_model[i]);
            if (i == 100) begin
                mem_we = 1'b1; mem_addr = 16'd50; mem_write_data = 32'hDEADBEEF;
                @(negedge clk);
                mem_we = 1'b0;
            end
        end
        wait_start();
        check_eq("max_core_size", core_size, 32'd960);
        core_read(16'd0, msg_model[0], "max_ram0");
        core_read(16'd50, msg_model[50], "load_we_ignored");
        core_read(16'd239, msg_model[239], "max_ram239");
        for (int i = 0; i < 8; i++) rnd_dig[i] = $urandom;
        core_write_digest(rnd_dig, 1'b1);
        drain(1'b1);
        @(negedge clk);

        // done still high from the previous run must not end this one.
        send_cmd(32'd4);
        send_word(32'h01020304);
        wait_start();
        for (int i = 0; i < 8; i++) rnd_dig[i] = $urandom;
        core_write_digest(rnd_dig, 1'b0);
        repeat (10) @(negedge clk);
        check_eq("held_done_no_drain", 32'(dig_valid), 32'd0);
        check_eq("held_done_state", 32'(dbg_state), 32'd3);
        core_done = 1'b0;
        @(negedge clk);
        core_done = 1'b1;
        drain(1'b0);
        core_done = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of a run.
        send_cmd(32'd0);
        wait_start();
        check_eq("mid_run_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_run_busy", 32'(busy), 32'd0);
        check_eq("rst_run_dig_valid", 32'(dig_valid), 32'd0);
        check_eq("rst_run_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset while a digest word is being offered.
        send_cmd(32'd0);
        wait_start();
        for (int i = 0; i < 8; i++) rnd_dig[i] = $urandom;
        core_write_digest(rnd_dig, 1'b1);
        for (int t = 0; t < 20 && !dig_valid; t++) @(negedge clk);
        check_eq("drain_valid_seen", 32'(dig_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_drain_dig_valid", 32'(dig_valid), 32'd0);
        check_eq("rst_drain_busy", 32'(busy), 32'd0);
        exp_q.delete();
        core_done = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
